// File: rtl/handshake_arbiter.sv
// Write-side controller sharing one 4-phase handshake CDC channel between
// NUM_SRC requesters with round-robin arbitration and per-phase timeout.
module handshake_arbiter #(
  parameter int unsigned NUM_SRC        = 4,
  parameter int unsigned DATA_WIDTH     = 12,
  parameter int unsigned SETUP_CYCLES   = 1,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  localparam int unsigned ID_W          = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                          wr_clk,
  input  logic                          wr_reset,
  input  logic [NUM_SRC-1:0]            src_valid,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
  output logic [NUM_SRC-1:0]            src_ready,
  output logic [DATA_WIDTH-1:0]         hs_data,
  output logic                          hs_req,
  input  logic                          hs_ack,
  output logic [ID_W-1:0]               grant_id,
  output logic                          busy,
  output logic                          done,
  output logic                          err
);

  localparam int unsigned CNT_MAX = (TIMEOUT_CYCLES > SETUP_CYCLES) ? TIMEOUT_CYCLES
                                                                    : SETUP_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    REQ   = 3'd2,
    DROP  = 3'd3,
    ERR   = 3'd4
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    hs_req_q, hs_req_d;
  logic [DATA_WIDTH-1:0]   hs_data_q, hs_data_d;
  logic [NUM_SRC-1:0]      src_ready_q, src_ready_d;
  logic [ID_W-1:0]         grant_q, grant_d;
  logic [ID_W-1:0]         rr_q, rr_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;

  logic                    win_found_c;
  logic [ID_W-1:0]         win_idx_c;
  logic [DATA_WIDTH-1:0]   src_word [NUM_SRC];

  // Modular add within [0, NUM_SRC); both operands are already in range.
  function automatic logic [ID_W-1:0] rr_add(input logic [ID_W-1:0] base,
                                             input int unsigned     off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= NUM_SRC) sum = sum - NUM_SRC;
    return ID_W'(sum);
  endfunction

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_unpack
    assign src_word[g] = src_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // First requesting source at or after the round-robin pointer.
  always_comb begin
    win_found_c = 1'b0;
    win_idx_c   = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      if (!win_found_c && src_valid[rr_add(rr_q, k)]) begin
        win_found_c = 1'b1;
        win_idx_c   = rr_add(rr_q, k);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hs_req_d    = hs_req_q;
    hs_data_d   = hs_data_q;
    src_ready_d = '0;
    grant_d     = grant_q;
    rr_d        = rr_q;
    done_d      = 1'b0;
    err_d       = err_q;

    case (state_q)
      IDLE: begin
        // A stale ack from the far side blocks launch.
        if (win_found_c && !hs_ack) begin
          state_d                = SETUP;
          cnt_d                  = '0;
          hs_data_d              = src_word[win_idx_c];
          grant_d                = win_idx_c;
          src_ready_d[win_idx_c] = 1'b1;
          rr_d                   = rr_add(win_idx_c, 1);
        end
      end
      SETUP: begin
        if (cnt_q == CNT_W'(SETUP_CYCLES)) begin
          state_d  = REQ;
          cnt_d    = '0;
          hs_req_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      REQ: begin
        if (hs_ack) begin
          state_d  = DROP;
          cnt_d    = '0;
          hs_req_d = 1'b0;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d  = ERR;
          hs_req_d = 1'b0;
          err_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DROP: begin
        if (!hs_ack) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = ERR;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ERR: begin
        if (!hs_ack) state_d = IDLE;
      end
      default: begin
        state_d  = IDLE;
        hs_req_d = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge wr_clk) begin
    if (wr_reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      hs_req_q    <= 1'b0;
      hs_data_q   <= '0;
      src_ready_q <= '0;
      grant_q     <= '0;
      rr_q        <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hs_req_q    <= hs_req_d;
      hs_data_q   <= hs_data_d;
      src_ready_q <= src_ready_d;
      grant_q     <= grant_d;
      rr_q        <= rr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign src_ready = src_ready_q;
  assign hs_data   = hs_data_q;
  assign hs_req    = hs_req_q;
  assign grant_id  = grant_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule
